// File: rtl/pll_sup_pkg.sv
// Shared definitions for the PLL clock supervisor: FSM states and default limits.
package pll_sup_pkg;

  typedef enum logic [1:0] {
    ST_FILTER = 2'd0,
    ST_RUN    = 2'd1,
    ST_HOLD   = 2'd2
  } sup_state_t;

  localparam int DEF_LOCK_FILTER = 1024;
  localparam int DEF_HOLD_CYCLES = 16;
  localparam int LOSS_CNT_W      = 8;

endpackage

// File: rtl/ce_divider.sv
// One clock-enable channel: latches a divide ratio per period and emits a
// registered single-cycle enable on the last count of each period.
module ce_divider
  import pll_sup_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run_en,
  input  logic             run_start,
  input  logic [DIV_W-1:0] div_ratio,
  output logic             ce
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  logic [DIV_W-1:0] ratio_q, ratio_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             ce_q, ce_d;

  // An idle channel treats its sampling cycle as count 0, so the next count is 1.
  always_comb begin
    ratio_d = '0;
    cnt_d   = '0;
    ce_d    = 1'b0;
    if (run_en) begin
      if (run_start) begin
        ratio_d = div_ratio;
        cnt_d   = '0;
      end else if (ratio_q == '0) begin
        ratio_d = div_ratio;
        cnt_d   = (div_ratio > ONE) ? ONE : '0;
      end else if (cnt_q == ratio_q - ONE) begin
        ratio_d = div_ratio;
        cnt_d   = '0;
      end else begin
        ratio_d = ratio_q;
        cnt_d   = cnt_q + ONE;
      end
      ce_d = (ratio_d != '0) && (cnt_d == ratio_d - ONE);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ratio_q <= '0;
      cnt_q   <= '0;
      ce_q    <= 1'b0;
    end else begin
      ratio_q <= ratio_d;
      cnt_q   <= cnt_d;
      ce_q    <= ce_d;
    end
  end

  assign ce = ce_q;

endmodule

// File: rtl/pll_clk_supervisor.sv
// PLL lock filter, system reset sequencer and programmable clock-enable
// generator running entirely in the PLL output clock domain.
module pll_clk_supervisor
  import pll_sup_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int DIV_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_FILTER = DEF_LOCK_FILTER,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    pll_locked,
  input  logic [NUM_CH*DIV_W-1:0] div_ratio,
  output logic                    sys_reset_n,
  output logic                    ready,
  output logic [NUM_CH-1:0]       ce,
  output logic [LOSS_CNT_W-1:0]   lock_loss_cnt
);

  localparam int FILT_W = $clog2(LOCK_FILTER);
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [FILT_W-1:0]     FILT_LAST = FILT_W'(LOCK_FILTER - 1);
  localparam logic [FILT_W-1:0]     FILT_ONE  = FILT_W'(1);
  localparam logic [HOLD_W-1:0]     HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0]     HOLD_ONE  = HOLD_W'(1);
  localparam logic [LOSS_CNT_W-1:0] LOSS_ONE  = LOSS_CNT_W'(1);

  sup_state_t              state_q, state_d;
  logic [SYNC_STAGES-1:0]  sync_q, sync_d;
  logic [FILT_W-1:0]       filt_cnt_q, filt_cnt_d;
  logic [HOLD_W-1:0]       hold_cnt_q, hold_cnt_d;
  logic [LOSS_CNT_W-1:0]   lock_loss_cnt_q, lock_loss_cnt_d;
  logic                    sys_reset_n_q, sys_reset_n_d;
  logic                    ready_q, ready_d;
  logic                    locked_s;
  logic                    run_en;
  logic                    run_start;

  assign locked_s = sync_q[SYNC_STAGES-1];

  // Outputs are registered from the next state so they change with the state itself.
  always_comb begin
    sync_d          = {sync_q[SYNC_STAGES-2:0], pll_locked};
    state_d         = state_q;
    filt_cnt_d      = '0;
    hold_cnt_d      = '0;
    lock_loss_cnt_d = lock_loss_cnt_q;
    case (state_q)
      ST_FILTER: begin
        if (locked_s) begin
          if (filt_cnt_q == FILT_LAST) begin
            state_d = ST_RUN;
          end else begin
            filt_cnt_d = filt_cnt_q + FILT_ONE;
          end
        end
      end
      ST_RUN: begin
        if (!locked_s) begin
          state_d = ST_HOLD;
          if (lock_loss_cnt_q != '1) begin
            lock_loss_cnt_d = lock_loss_cnt_q + LOSS_ONE;
          end
        end
      end
      ST_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d = ST_FILTER;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_ONE;
        end
      end
      default: state_d = ST_FILTER;
    endcase
    run_en        = (state_d == ST_RUN);
    run_start     = run_en && (state_q != ST_RUN);
    sys_reset_n_d = run_en;
    ready_d       = run_en;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_FILTER;
      sync_q          <= '0;
      filt_cnt_q      <= '0;
      hold_cnt_q      <= '0;
      lock_loss_cnt_q <= '0;
      sys_reset_n_q   <= 1'b0;
      ready_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      sync_q          <= sync_d;
      filt_cnt_q      <= filt_cnt_d;
      hold_cnt_q      <= hold_cnt_d;
      lock_loss_cnt_q <= lock_loss_cnt_d;
      sys_reset_n_q   <= sys_reset_n_d;
      ready_q         <= ready_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ce_divider #(
      .DIV_W(DIV_W)
    ) u_div (
      .clk      (clk),
      .reset_n  (reset_n),
      .run_en   (run_en),
      .run_start(run_start),
      .div_ratio(div_ratio[i*DIV_W +: DIV_W]),
      .ce       (ce[i])
    );
  end

  assign sys_reset_n   = sys_reset_n_q;
  assign ready         = ready_q;
  assign lock_loss_cnt = lock_loss_cnt_q;

endmodule
